// File: rtl/parking_space_manager.sv
// Two-class (university/public) car-park space manager with an internal minute-of-day clock.
// Ports: clk/rst_n; min_tick/time_load/time_load_val drive the clock; entry_*/exit_* requests with
// registered acks one cycle later; occupancy, capacity, free/avail and evicted_cnt status outputs.
module parking_space_manager #(
  parameter int CNT_W       = 11,
  parameter int TOTAL_CAP   = 700,
  parameter int UNI_DAY_CAP = 500,
  parameter int UNI_EVE_CAP = 200,
  parameter int SHIFT_STEP  = 50,
  parameter int OPEN_MIN    = 480,
  parameter int SHIFT_MIN   = 780,
  parameter int EVE_MIN     = 960,
  parameter int CLOSE_MIN   = 1200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             min_tick,
  input  logic             time_load,
  input  logic [10:0]      time_load_val,
  input  logic             entry_req,
  input  logic             entry_is_uni,
  input  logic             exit_req,
  input  logic             exit_is_uni,
  output logic             entry_ack,
  output logic             entry_granted,
  output logic             entry_class,
  output logic             exit_ack,
  output logic             exit_ok,
  output logic [10:0]      minute_of_day,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] uni_parked,
  output logic [CNT_W-1:0] pub_parked,
  output logic [CNT_W-1:0] uni_cap,
  output logic [CNT_W-1:0] pub_cap,
  output logic [CNT_W-1:0] uni_free,
  output logic [CNT_W-1:0] pub_free,
  output logic             uni_avail,
  output logic             pub_avail,
  output logic [15:0]      evicted_cnt
);

  typedef enum logic [1:0] {PH_CLOSED = 2'd0, PH_DAY = 2'd1, PH_SHIFT = 2'd2, PH_EVE = 2'd3} phase_t;

  localparam logic [10:0] OPEN_M  = 11'(OPEN_MIN);
  localparam logic [10:0] SHIFT_M = 11'(SHIFT_MIN);
  localparam logic [10:0] EVE_M   = 11'(EVE_MIN);
  localparam logic [10:0] CLOSE_M = 11'(CLOSE_MIN);
  localparam int          SOFF    = SHIFT_MIN % 60;
  localparam int          SHIFT_HOURS = (EVE_MIN - SHIFT_MIN + 59) / 60;
  localparam logic [CNT_W-1:0] DAY_CAP  = CNT_W'(UNI_DAY_CAP);
  localparam logic [CNT_W-1:0] EVE_CAP  = CNT_W'(UNI_EVE_CAP);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(SHIFT_STEP);
  localparam logic [CNT_W-1:0] TOT_CAP  = CNT_W'(TOTAL_CAP);

  phase_t           phase_q, phase_d;
  logic [10:0]      minute_q, minute_d;
  logic [5:0]       mih_q, mih_d;   // (minute - SHIFT_MIN) mod 60, kept incrementally
  logic [CNT_W-1:0] ucap_q, ucap_d, pcap_q, pcap_d;
  logic [CNT_W-1:0] uni_q, pub_q;
  logic [CNT_W:0]   uni_w, pub_w;   // one spare bit: migration can briefly push pub past 2^CNT_W
  logic [15:0]      ev_q, ev_d;
  logic [16:0]      ev_sum;
  logic [CNT_W:0]   excess;
  logic             min_chg;
  logic             ent_ack_q, ent_gnt_q, ent_cls_q, ext_ack_q, ext_ok_q;
  logic             ent_gnt_d, ent_cls_d, ext_ok_d;

  function automatic phase_t phase_of(input logic [10:0] m);
    if (m >= OPEN_M && m < SHIFT_M)       phase_of = PH_DAY;
    else if (m >= SHIFT_M && m < EVE_M)   phase_of = PH_SHIFT;
    else if (m >= EVE_M && m < CLOSE_M)   phase_of = PH_EVE;
    else                                  phase_of = PH_CLOSED;
  endfunction

  // Minute-in-hour for an arbitrary loaded minute: constant compares instead of a divider.
  function automatic logic [5:0] mih_of(input logic [10:0] m);
    logic [10:0] r;
    r = m;
    for (int h = 1; h < 24; h++)
      if (m >= 11'(h * 60)) r = m - 11'(h * 60);
    if (r >= 11'(SOFF)) mih_of = 6'(r - 11'(SOFF));
    else                mih_of = 6'(r + 11'(60 - SOFF));
  endfunction

  // University capacity when jumping straight into the SHIFT window.
  function automatic logic [CNT_W-1:0] shift_cap_load(input logic [10:0] m);
    int hrs;
    int c;
    hrs = 0;
    for (int k = 1; k <= SHIFT_HOURS; k++)
      if (m >= 11'(SHIFT_MIN + 60 * k)) hrs = k;
    c = UNI_DAY_CAP - SHIFT_STEP * (hrs + 1);
    if (c < UNI_EVE_CAP) c = UNI_EVE_CAP;
    shift_cap_load = CNT_W'(c);
  endfunction

  always_comb begin
    minute_d  = minute_q;
    mih_d     = mih_q;
    phase_d   = phase_q;
    ucap_d    = ucap_q;
    pcap_d    = pcap_q;
    ev_d      = ev_q;
    ev_sum    = '0;
    excess    = '0;
    ent_gnt_d = 1'b0;
    ent_cls_d = 1'b0;
    ext_ok_d  = 1'b0;
    uni_w     = {1'b0, uni_q};
    pub_w     = {1'b0, pub_q};
    min_chg   = time_load | min_tick;

    if (time_load) begin
      minute_d = (time_load_val > 11'd1439) ? 11'd0 : time_load_val;
      mih_d    = mih_of(minute_d);
    end else if (min_tick) begin
      minute_d = (minute_q == 11'd1439) ? 11'd0 : minute_q + 11'd1;
      mih_d    = (mih_q == 6'd59) ? 6'd0 : mih_q + 6'd1;
    end

    // 1: capacities follow the new minute
    if (min_chg) begin
      phase_d = phase_of(minute_d);
      case (phase_d)
        PH_DAY:   ucap_d = DAY_CAP;
        PH_SHIFT: begin
          if (time_load)        ucap_d = shift_cap_load(minute_d);
          else if (mih_d == '0) ucap_d = (ucap_q >= EVE_CAP + STEP) ? ucap_q - STEP : EVE_CAP;
        end
        PH_EVE:   ucap_d = EVE_CAP;
        default:  ucap_d = '0;
      endcase
      pcap_d = (phase_d == PH_CLOSED) ? '0 : TOT_CAP - ucap_d;
    end

    // Reopening starts a fresh day.
    if (phase_d == PH_DAY && phase_q == PH_CLOSED) begin
      uni_w = '0;
      pub_w = '0;
      ev_d  = '0;
    end

    // 2: overflow university cars move to public spaces
    if (uni_w > {1'b0, ucap_d}) begin
      pub_w = pub_w + (uni_w - {1'b0, ucap_d});
      uni_w = {1'b0, ucap_d};
    end

    // 3: whatever still does not fit is evicted
    if (pub_w > {1'b0, pcap_d}) begin
      excess = pub_w - {1'b0, pcap_d};
      pub_w  = {1'b0, pcap_d};
      ev_sum = {1'b0, ev_d} + 17'(excess);
      ev_d   = ev_sum[16] ? 16'hFFFF : ev_sum[15:0];
    end

    // 4: exit
    if (exit_req) begin
      if (exit_is_uni) begin
        if (uni_w != '0) begin uni_w = uni_w - 1'b1; ext_ok_d = 1'b1; end
      end else begin
        if (pub_w != '0) begin pub_w = pub_w - 1'b1; ext_ok_d = 1'b1; end
      end
    end

    // 5: entry sees post-exit counts, so a same-cycle exit frees a space
    if (entry_req && phase_d != PH_CLOSED) begin
      if (entry_is_uni && uni_w < {1'b0, ucap_d}) begin
        uni_w = uni_w + 1'b1; ent_gnt_d = 1'b1; ent_cls_d = 1'b1;
      end else if (pub_w < {1'b0, pcap_d}) begin
        pub_w = pub_w + 1'b1; ent_gnt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minute_q  <= '0;
      mih_q     <= '0;
      phase_q   <= PH_CLOSED;
      ucap_q    <= '0;
      pcap_q    <= '0;
      uni_q     <= '0;
      pub_q     <= '0;
      ev_q      <= '0;
      ent_ack_q <= 1'b0;
      ent_gnt_q <= 1'b0;
      ent_cls_q <= 1'b0;
      ext_ack_q <= 1'b0;
      ext_ok_q  <= 1'b0;
    end else begin
      minute_q  <= minute_d;
      mih_q     <= mih_d;
      phase_q   <= phase_d;
      ucap_q    <= ucap_d;
      pcap_q    <= pcap_d;
      uni_q     <= uni_w[CNT_W-1:0];
      pub_q     <= pub_w[CNT_W-1:0];
      ev_q      <= ev_d;
      ent_ack_q <= entry_req;
      ent_gnt_q <= ent_gnt_d;
      ent_cls_q <= ent_cls_d;
      ext_ack_q <= exit_req;
      ext_ok_q  <= ext_ok_d;
    end
  end

  assign minute_of_day = minute_q;
  assign phase         = phase_q;
  assign uni_cap       = ucap_q;
  assign pub_cap       = pcap_q;
  assign uni_parked    = uni_q;
  assign pub_parked    = pub_q;
  assign evicted_cnt   = ev_q;
  assign entry_ack     = ent_ack_q;
  assign entry_granted = ent_gnt_q;
  assign entry_class   = ent_cls_q;
  assign exit_ack      = ext_ack_q;
  assign exit_ok       = ext_ok_q;
  assign uni_free      = (ucap_q > uni_q) ? ucap_q - uni_q : '0;
  assign pub_free      = (pcap_q > pub_q) ? pcap_q - pub_q : '0;
  assign uni_avail     = (uni_free != '0);
  assign pub_avail     = (pub_free != '0);

endmodule

// File: tb/tb_parking_space_manager.sv
module tb_parking_space_manager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        min_tick = 0, time_load = 0, entry_req = 0, entry_is_uni = 0, exit_req = 0, exit_is_uni = 0;
  logic [10:0] time_load_val = '0;
  logic        entry_ack, entry_granted, entry_class, exit_ack, exit_ok, uni_avail, pub_avail;
  logic [10:0] minute_of_day;
  logic [1:0]  phase;
  logic [10:0] uni_parked, pub_parked, uni_cap, pub_cap, uni_free, pub_free;
  logic [15:0] evicted_cnt;

  int checks = 0;
  int errors = 0;

  parking_space_manager dut (
    .clk(clk), .rst_n(rst_n), .min_tick(min_tick), .time_load(time_load), .time_load_val(time_load_val),
    .entry_req(entry_req), .entry_is_uni(entry_is_uni), .exit_req(exit_req), .exit_is_uni(exit_is_uni),
    .entry_ack(entry_ack), .entry_granted(entry_granted), .entry_class(entry_class),
    .exit_ack(exit_ack), .exit_ok(exit_ok), .minute_of_day(minute_of_day), .phase(phase),
    .uni_parked(uni_parked), .pub_parked(pub_parked), .uni_cap(uni_cap), .pub_cap(pub_cap),
    .uni_free(uni_free), .pub_free(pub_free), .uni_avail(uni_avail), .pub_avail(pub_avail),
    .evicted_cnt(evicted_cnt)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    min_tick = 1; cycle(); min_tick = 0;
  endtask

  task automatic load(input logic [10:0] v);
    time_load = 1; time_load_val = v; cycle(); time_load = 0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({minute_of_day, phase, uni_parked, pub_parked, uni_cap, pub_cap, evicted_cnt,
         entry_ack, entry_granted, exit_ack, exit_ok} !== '0) begin
      errors++; $display("FAIL reset_state: got minute=%0d phase=%0d caps=%0d/%0d expected all 0",
                         minute_of_day, phase, uni_cap, pub_cap);
    end
    #9 rst_n = 1;
    cycle();
  endtask

  task automatic test_open();
    load(11'd479);
    checks++;
    if (phase !== 2'd0) begin errors++; $display("FAIL closed_at_479: phase=%0d expected 0", phase); end
    tick();
    checks++;
    if (minute_of_day !== 11'd480 || phase !== 2'd1 || uni_cap !== 11'd500 || pub_cap !== 11'd200 ||
        uni_parked !== 0 || pub_parked !== 0 || evicted_cnt !== 0) begin
      errors++; $display("FAIL open_day: min=%0d phase=%0d caps=%0d/%0d parked=%0d/%0d ev=%0d expected 480 1 500/200 0/0 0",
                         minute_of_day, phase, uni_cap, pub_cap, uni_parked, pub_parked, evicted_cnt);
    end
  endtask

  task automatic test_day_fill();
    entry_req = 1; entry_is_uni = 1;
    repeat (500) @(posedge clk);
    #1;
    checks++;
    if (uni_parked !== 11'd500 || uni_free !== 0 || uni_avail !== 0 || entry_class !== 1'b1) begin
      errors++; $display("FAIL uni_fill: uni=%0d free=%0d avail=%0d class=%0d expected 500 0 0 1",
                         uni_parked, uni_free, uni_avail, entry_class);
    end
    cycle();  // 501st uni entry falls over to a public space
    entry_req = 0;
    checks++;
    if (entry_ack !== 1 || entry_granted !== 1 || entry_class !== 0 || uni_parked !== 500 || pub_parked !== 1) begin
      errors++; $display("FAIL uni_overflow: ack=%0d gnt=%0d class=%0d parked=%0d/%0d expected 1 1 0 500/1",
                         entry_ack, entry_granted, entry_class, uni_parked, pub_parked);
    end
    cycle();
    checks++;
    if (entry_ack !== 0 || entry_granted !== 0) begin
      errors++; $display("FAIL ack_one_cycle: ack=%0d gnt=%0d expected 0 0", entry_ack, entry_granted);
    end
  endtask

  task automatic test_back_to_back();
    entry_req = 1; entry_is_uni = 0;
    repeat (199) @(posedge clk);
    #1 entry_req = 0;
    checks++;
    if (pub_parked !== 11'd200 || pub_free !== 0 || pub_avail !== 0) begin
      errors++; $display("FAIL pub_fill: pub=%0d free=%0d avail=%0d expected 200 0 0", pub_parked, pub_free, pub_avail);
    end
    exit_req = 1; exit_is_uni = 1; entry_req = 1; entry_is_uni = 1;
    cycle();
    exit_req = 0; entry_req = 0;
    checks++;
    if (entry_ack !== 1 || entry_granted !== 1 || entry_class !== 1 || exit_ack !== 1 || exit_ok !== 1 ||
        uni_parked !== 500 || pub_parked !== 200) begin
      errors++; $display("FAIL swap_full: gnt=%0d class=%0d xack=%0d ok=%0d parked=%0d/%0d expected 1 1 1 1 500/200",
                         entry_granted, entry_class, exit_ack, exit_ok, uni_parked, pub_parked);
    end
    entry_req = 1; entry_is_uni = 0;
    cycle();
    entry_req = 0;
    checks++;
    if (entry_ack !== 1 || entry_granted !== 0 || pub_parked !== 200) begin
      errors++; $display("FAIL pub_denied: ack=%0d gnt=%0d pub=%0d expected 1 0 200", entry_ack, entry_granted, pub_parked);
    end
  endtask

  task automatic test_shift();
    load(11'd779);
    tick();
    checks++;
    if (phase !== 2'd2 || uni_cap !== 450 || pub_cap !== 250 || uni_parked !== 450 || pub_parked !== 250 || evicted_cnt !== 0) begin
      errors++; $display("FAIL shift_780: ph=%0d caps=%0d/%0d parked=%0d/%0d ev=%0d expected 2 450/250 450/250 0",
                         phase, uni_cap, pub_cap, uni_parked, pub_parked, evicted_cnt);
    end
    for (int i = 0; i < 59; i++) tick();
    checks++;
    if (uni_cap !== 450) begin errors++; $display("FAIL shift_839: uni_cap=%0d expected 450", uni_cap); end
    tick();
    checks++;
    if (minute_of_day !== 840 || uni_cap !== 400 || pub_cap !== 300 || uni_parked !== 400 || pub_parked !== 300 || evicted_cnt !== 0) begin
      errors++; $display("FAIL shift_840: min=%0d caps=%0d/%0d parked=%0d/%0d ev=%0d expected 840 400/300 400/300 0",
                         minute_of_day, uni_cap, pub_cap, uni_parked, pub_parked, evicted_cnt);
    end
    load(11'd900);  // two hours elapsed: 500 - 3*50
    checks++;
    if (uni_cap !== 350 || pub_cap !== 350 || uni_parked !== 350 || pub_parked !== 350) begin
      errors++; $display("FAIL shift_load_900: caps=%0d/%0d parked=%0d/%0d expected 350/350 350/350",
                         uni_cap, pub_cap, uni_parked, pub_parked);
    end
    load(11'd960);
    checks++;
    if (phase !== 2'd3 || uni_cap !== 200 || pub_cap !== 500 || uni_parked !== 200 || pub_parked !== 500 || evicted_cnt !== 0) begin
      errors++; $display("FAIL evening: ph=%0d caps=%0d/%0d parked=%0d/%0d ev=%0d expected 3 200/500 200/500 0",
                         phase, uni_cap, pub_cap, uni_parked, pub_parked, evicted_cnt);
    end
  endtask

  task automatic test_close();
    load(11'd1199);
    tick();
    checks++;
    if (phase !== 2'd0 || uni_cap !== 0 || pub_cap !== 0 || uni_parked !== 0 || pub_parked !== 0 || evicted_cnt !== 700) begin
      errors++; $display("FAIL close: ph=%0d caps=%0d/%0d parked=%0d/%0d ev=%0d expected 0 0/0 0/0 700",
                         phase, uni_cap, pub_cap, uni_parked, pub_parked, evicted_cnt);
    end
    entry_req = 1; entry_is_uni = 1;
    cycle();
    entry_req = 0;
    checks++;
    if (entry_ack !== 1 || entry_granted !== 0 || uni_parked !== 0) begin
      errors++; $display("FAIL closed_entry: ack=%0d gnt=%0d uni=%0d expected 1 0 0", entry_ack, entry_granted, uni_parked);
    end
  endtask

  task automatic test_exit_empty_and_reset();
    exit_req = 1; exit_is_uni = 0;
    cycle();
    exit_req = 0;
    checks++;
    if (exit_ack !== 1 || exit_ok !== 0 || pub_parked !== 0) begin
      errors++; $display("FAIL exit_empty: ack=%0d ok=%0d pub=%0d expected 1 0 0", exit_ack, exit_ok, pub_parked);
    end
    load(11'd1439);
    tick();
    checks++;
    if (minute_of_day !== 0 || phase !== 0) begin
      errors++; $display("FAIL wrap: min=%0d ph=%0d expected 0 0", minute_of_day, phase);
    end
    load(11'd2000);
    checks++;
    if (minute_of_day !== 0) begin errors++; $display("FAIL load_oob: min=%0d expected 0", minute_of_day); end
    load(11'd479);
    tick();
    checks++;
    if (phase !== 1 || evicted_cnt !== 0 || uni_cap !== 500) begin
      errors++; $display("FAIL reopen: ph=%0d ev=%0d uni_cap=%0d expected 1 0 500", phase, evicted_cnt, uni_cap);
    end
    entry_req = 1; entry_is_uni = 1;
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    checks++;
    if ({minute_of_day, phase, uni_parked, pub_parked, uni_cap, pub_cap, evicted_cnt, entry_ack, entry_granted, entry_class} !== '0) begin
      errors++; $display("FAIL async_reset: min=%0d ph=%0d uni=%0d cap=%0d ack=%0d expected all 0",
                         minute_of_day, phase, uni_parked, uni_cap, entry_ack);
    end
    entry_req = 0;
    #10 rst_n = 1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_open();
    test_day_fill();
    test_back_to_back();
    test_shift();
    test_close();
    test_exit_empty_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
